seg_scan_decoder: RTL and testbench

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

---
 rtl/seg_pkg.sv | 22 ++
 rtl/seg_pattern_decode.sv | 18 +
 rtl/seg_scan_decoder.sv | 89 ++++++++
 tb/tb_seg_scan_decoder.sv | 89 ++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared 7-segment pattern constants and scan FSM state encodings.
package seg_pkg;
    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;
    localparam logic [6:0] SEG_7 = 7'b1110000;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1111011;
    localparam logic [6:0] SEG_A = 7'b1110111;
    localparam logic [6:0] SEG_B = 7'b0011111;
    localparam logic [6:0] SEG_C = 7'b0001101;
    localparam logic [6:0] SEG_D = 7'b0111101;
    localparam logic [6:0] SEG_E = 7'b1001111;
    localparam logic [6:0] SEG_F = 7'b1000111;
    localparam logic [15:0][6:0] SEG_TABLE = {SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
                                              SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};
    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;
endpackage

// File: rtl/seg_pattern_decode.sv
// seg_pattern_decode: segment pattern to hex nibble, flagging unknown patterns.
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] leds,
    output logic [3:0] nibble,
    output logic       legal
);
    always_comb begin
        nibble = '0;
        legal = 1'b0;
        for (int i = 0; i < 16; i++)
            if (leds == SEG_TABLE[i]) begin
                nibble = 4'(i);
                legal = 1'b1;
            end
    end
endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: recovers hex digits from a multiplexed 4-digit 7-segment scan
// by debouncing each (anode, segment) sample before capturing it.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  an,
    input  logic [6:0]  leds,
    input  logic        clr,
    output logic [15:0] digits,
    output logic [3:0]  valid,
    output logic        err,
    output logic        frame_done
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] MAX = CW'(STABLE_CYCLES);
    state_t state, state_n;
    logic [CW-1:0] count, count_n;
    logic [10:0] ref_sample, ref_n;
    logic [15:0] digits_n;
    logic [3:0] valid_n, seen, seen_n, sel, nibble;
    logic legal, ohl, same, cap;
    assign ohl = an == 4'b1110 || an == 4'b1101 || an == 4'b1011 || an == 4'b0111;
    assign same = {an, leds} == ref_sample;
    assign sel = ~an;
    seg_pattern_decode u_dec (.leds(leds), .nibble(nibble), .legal(legal));
    always_comb begin
        state_n = state;
        count_n = count;
        ref_n = ref_sample;
        cap = 1'b0;
        if (!ohl) begin
            state_n = IDLE;
            count_n = '0;
        end else if (state == SETTLE && same) begin
            count_n = count == MAX ? count : count + 1'b1;
            cap = count_n == MAX;
        end else if (state != HOLD || !same) begin
            state_n = SETTLE;
            count_n = CW'(1);
            ref_n = {an, leds};
            cap = count_n == MAX;
        end
        if (cap) state_n = HOLD;
    end
    // an illegal capture keeps the old nibble but withdraws its valid bit
    always_comb begin
        digits_n = digits;
        valid_n = valid;
        for (int i = 0; i < 4; i++)
            if (cap && sel[i]) begin
                digits_n[4*i +: 4] = legal ? nibble : digits[4*i +: 4];
                valid_n[i] = legal;
            end
    end
    assign seen_n = seen | (cap ? sel : 4'b0000);
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            count <= '0;
            ref_sample <= '0;
        end else begin
            state <= state_n;
            count <= count_n;
            ref_sample <= ref_n;
        end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            digits <= '0;
            valid <= '0;
            err <= 1'b0;
            seen <= '0;
            frame_done <= 1'b0;
        end else if (clr) begin
            valid <= '0;
            err <= 1'b0;
            seen <= '0;
            frame_done <= 1'b0;
        end else begin
            digits <= digits_n;
            valid <= valid_n;
            err <= err | (cap && !legal);
            frame_done <= &seen_n;
            seen <= &seen_n ? 4'b0000 : seen_n;
        end
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed scan vectors; a scoreboard queue holds the
// hand-computed outputs expected after each clock edge.
module tb_seg_scan_decoder;
    logic clk = 1'b0, rst = 1'b1, clr = 1'b0;
    logic [3:0] an = 4'hf;
    logic [6:0] leds = '0;
    logic [15:0] digits;
    logic [3:0] valid;
    logic err, frame_done;
    logic [21:0] exp_q[$];
    string tag_q[$];
    int vectors = 0, miscompares = 0;

    seg_scan_decoder #(.STABLE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .an(an), .leds(leds), .clr(clr),
        .digits(digits), .valid(valid), .err(err), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [21:0] o(logic [15:0] d, logic [3:0] v, logic e, logic f);
        return {d, v, e, f};
    endfunction

    function automatic void check(string name, logic [21:0] e);
        vectors++;
        if ({digits, valid, err, frame_done} !== e) begin
            miscompares++;
            $display("FAIL %s: got digits=%h valid=%b err=%b fd=%b, want digits=%h valid=%b err=%b fd=%b",
                     name, digits, valid, err, frame_done, e[21:6], e[5:2], e[1], e[0]);
        end
    endfunction

    always @(posedge clk) begin
        #2;
        if (exp_q.size() != 0) check(tag_q.pop_front(), exp_q.pop_front());
    end

    task automatic step(string tag, input logic [3:0] a, input logic [6:0] l,
                        input logic c, input logic r, input logic [21:0] x);
        an = a;
        leds = l;
        clr = c;
        rst = r;
        exp_q.push_back(x);
        tag_q.push_back(tag);
        @(posedge clk);
        #3;
    endtask

    task automatic run(string tag, input logic [3:0] a, input logic [6:0] l, input int n,
                       input logic [21:0] pre, input logic [21:0] post);
        for (int i = 0; i < n - 1; i++) step(tag, a, l, 1'b0, 1'b0, pre);
        step(tag, a, l, 1'b0, 1'b0, post);
    endtask

    initial begin
        step("reset", 4'hf, 7'b0, 1'b0, 1'b1, o(16'h0, 4'b0, 1'b0, 1'b0));
        run("d0_3", 4'b1110, 7'b1111001, 4, o(16'h0, 4'b0, 0, 0), o(16'h0003, 4'b0001, 0, 0));
        step("idle", 4'hf, 7'b0, 1'b0, 1'b0, o(16'h0003, 4'b0001, 0, 0));
        run("d1_4_short", 4'b1101, 7'b0110011, 2, o(16'h0003, 4'b0001, 0, 0), o(16'h0003, 4'b0001, 0, 0));
        run("d1_5", 4'b1101, 7'b1011011, 4, o(16'h0003, 4'b0001, 0, 0), o(16'h0053, 4'b0011, 0, 0));
        step("hold", 4'b1101, 7'b1011011, 1'b0, 1'b0, o(16'h0053, 4'b0011, 0, 0));
        run("d2_illegal", 4'b1011, 7'b0000001, 4, o(16'h0053, 4'b0011, 0, 0), o(16'h0053, 4'b0011, 1, 0));
        step("clr", 4'hf, 7'b0, 1'b1, 1'b0, o(16'h0053, 4'b0000, 0, 0));
        run("two_anodes", 4'b1100, 7'b1111111, 10, o(16'h0053, 4'b0, 0, 0), o(16'h0053, 4'b0, 0, 0));
        run("scan_A", 4'b1110, 7'b1110111, 4, o(16'h0053, 4'b0000, 0, 0), o(16'h005A, 4'b0001, 0, 0));
        run("scan_b", 4'b1101, 7'b0011111, 4, o(16'h005A, 4'b0001, 0, 0), o(16'h00bA, 4'b0011, 0, 0));
        run("scan_c", 4'b1011, 7'b0001101, 4, o(16'h00bA, 4'b0011, 0, 0), o(16'h0cbA, 4'b0111, 0, 0));
        run("scan_d", 4'b0111, 7'b0111101, 4, o(16'h0cbA, 4'b0111, 0, 0), o(16'hdcbA, 4'b1111, 0, 1));
        step("fd_off", 4'b0111, 7'b0111101, 1'b0, 1'b0, o(16'hdcbA, 4'b1111, 0, 0));
        run("recap_8", 4'b1101, 7'b1111111, 4, o(16'hdcbA, 4'b1111, 0, 0), o(16'hdc8A, 4'b1111, 0, 0));
        run("pre_rst", 4'b1110, 7'b1111110, 2, o(16'hdc8A, 4'b1111, 0, 0), o(16'hdc8A, 4'b1111, 0, 0));
        rst = 1'b1;
        #1;
        check("rst_async", o(16'h0, 4'b0, 0, 0));
        step("rst_edge", 4'b1110, 7'b1111110, 1'b0, 1'b1, o(16'h0, 4'b0, 0, 0));
        run("post_rst", 4'b1110, 7'b1111110, 4, o(16'h0, 4'b0, 0, 0), o(16'h0, 4'b0001, 0, 0));
        @(posedge clk);
        #3;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
